sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
- Sequences data-memory accesses from the MEM stage onto a 16-bit external SRAM. Each 32-bit LDR/STR becomes two half-word SRAM transactions, each with a fixed wait time.
- Drives `ready` low while an access is in flight. The hazard/pipeline logic uses `~ready` as the global freeze.
- Sits between the MEM-stage register (`mem_read`, `mem_write`, ALU address, Rm value) and the SRAM pins. It replaces the single-cycle data-memory model.

Parameters:
- `BASE_ADDR`, 1024: first byte address of data memory in the CPU address map.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 3: cycles each half-word access is held. Legal range 2..15.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_read`  in  1: LDR request from the MEM stage, level, held until `ready`.
- `mem_write`  in  1: STR request from the MEM stage, level, held until `ready`.
- `address`  in  32: byte address from the ALU.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data.
- `ready`  out  1: access complete / controller idle. Pipeline freeze = `~ready`.
- `err`  out  1: address fault pulse. Only active with the optional feature.
- `sram_addr`  out  `SRAM_AW`: SRAM half-word address.
- `sram_dq_out`  out  16: write data to the pad.
- `sram_dq_oe`  out  1: pad output enable.
- `sram_dq_in`  in  16: read data from the pad.
- `sram_we_n`  out  1: SRAM write strobe, active-low.
- `sram_oe_n`  out  1: SRAM output enable, active-low.

Behaviour:
- Reset (async, `rst`=0), effective immediately, including mid-access:
  - state=IDLE, counter=0, `rdata`=0, `err`=0.
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
  - A partially written word is left as-is in the SRAM.
- States: IDLE, LO, HI, DONE.
  - IDLE: if `mem_read` or `mem_write`, latch `address`, `wdata` and the direction, then go to LO.
  - Request priority: `mem_read` wins if both are high.
  - LO: counter counts 0..`WAIT_CYCLES`-1. At `WAIT_CYCLES`-1, clear the counter and go to HI.
  - HI: same counting, then go to DONE.
  - DONE: one cycle, then go to IDLE unconditionally.
- Address mapping:
  - `wa = (address - BASE_ADDR) >> 2`, modulo 2^32.
  - LO uses `sram_addr = {wa, 1'b0}`; HI uses `{wa, 1'b1}`. Both truncated to `SRAM_AW`.
  - `address[1:0]` is ignored.
- Write strobes:
  - `sram_dq_oe`=1 through all of LO and HI.
  - `sram_dq_out` = `wdata[15:0]` in LO and `wdata[31:16]` in HI.
  - `sram_we_n`=0 for counter 0..`WAIT_CYCLES`-2 and 1 on the last count of each half (address/data hold).
  - `sram_oe_n`=1 throughout.
- Read strobes:
  - `sram_oe_n`=0 through LO and HI.
  - `sram_dq_in` is sampled on the last count: into `rdata[15:0]` in LO and `rdata[31:16]` in HI.
  - `rdata` is updated only by reads and is held otherwise. It is valid from DONE until the next read's LO sample.
- `ready` (combinational) = `(IDLE && !mem_read && !mem_write) || DONE`.
- Latency, with cycle 0 = the IDLE cycle where the request is seen:
  - LO occupies cycles 1..W, HI occupies W+1..2W, DONE is cycle 2W+1.
  - `ready` is low for 2W+1 cycles, i.e. 7 for W=3.
- Back-to-back: the pipeline advances on the DONE edge. A new request seen in the following IDLE cycle starts immediately, so there is one IDLE cycle between accesses.
- A request dropped mid-access is ignored; the latched access completes.

Optional Feature:
- Macro: `SRAM_ACCESS_CTRL_ADDR_CHECK_EN`.
- With the macro defined:
  - In IDLE, the request faults if `address[1:0]`≠0, or `address`<`BASE_ADDR`, or `wa` ≥ 2^(`SRAM_AW`-1).
  - A faulting request goes directly to DONE: no SRAM strobes, `rdata` unchanged, `err`=1 in that DONE cycle only. `ready` is low for exactly 1 cycle.
- Without the macro: no range or alignment check, and `err` is tied to 0.

Decomposition:
- Package `sram_ctrl_pkg`:
  - state enum / ST_IDLE..ST_DONE encodings (2-bit);
  - default `BASE_ADDR`, `SRAM_AW`, `WAIT_CYCLES`;
  - SRAM data width constant 16.
- One sub-module: `sram_wait_counter`.
  - 4-bit counter with clear and enable.
  - Outputs `last` (count == `WAIT_CYCLES`-1) and `hold` (count == `WAIT_CYCLES`-1, used for the `we_n` release).
  - Instantiated once.

Test Plan:
- Store then load: STR `address`=1024, `wdata`=0xDEADBEEF. Expect `sram_addr` 0 then 1, `dq_out` 0xBEEF then 0xDEAD, `ready` low 7 cycles. Then LDR 1024: expect `rdata`=0xDEADBEEF in DONE.
- Strobe timing, W=3 STR `address`=1028: `sram_addr`=2,3. `we_n` pattern per half is 0,0,1. `oe_n`=1 and `dq_oe`=1 for cycles 1..6, 0 elsewhere.
- Simultaneous `mem_read`=`mem_write`=1 at `address`=1032: a read is performed (`oe_n`=0, `we_n`=1 throughout) and the SRAM contents are unchanged.
- Reset mid-op: assert `rst`=0 during HI of a store. `ready`=1, `we_n`=1 and `dq_oe`=0 in the same cycle with no clock edge. After release, a read of 1024 completes normally in 7 cycles.
- Back-to-back: two consecutive LDRs at 1024 and 1028. Expect `ready` high on cycle 7, low on cycles 8..14, high on 15, with the second `rdata` correct.
- `ADDR_CHECK_EN` defined, LDR `address`=1026: `ready` low 1 cycle, `err` pulse 1 cycle, no SRAM strobe, `rdata` unchanged. LDR `address`=512 gives the same result.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller: FSM state encoding,
// default parameter values and the SRAM data width.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_SRAM_AW     = 18;
  localparam int unsigned DEF_WAIT_CYCLES = 3;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// MEM-stage side of the SRAM access controller: request, address/data and
// the ready/err/rdata responses. The pipeline is master, the controller slave.
interface sram_access_ctrl_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output mem_read, mem_write, address, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  mem_read, mem_write, address, wdata,
    output rdata, ready, err
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Per-half-word wait counter: counts 0..WAIT_CYCLES-1 while enabled, wraps to 0
// after the last count, and flags the last count for the FSM and the we_n release.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o,
  output logic hold_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign hold_o = last_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two timed half-word accesses on a
// 16-bit SRAM. Optional address fault check: SRAM_ACCESS_CTRL_ADDR_CHECK_EN.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_access_ctrl_if.slave    cpu,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  state_e             state_q, state_d;
  logic               rd_q, rd_d;
  logic [SRAM_AW-2:0] wa_q, wa_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               cnt_en, cnt_last, cnt_hold;
  logic               req, fault;
  logic [31:0]        wa_full;

  assign req     = cpu.mem_read | cpu.mem_write;
  assign wa_full = (cpu.address - 32'(BASE_ADDR)) >> 2;

`ifdef SRAM_ACCESS_CTRL_ADDR_CHECK_EN
  assign fault = (cpu.address[1:0] != 2'b00)
              || (cpu.address < 32'(BASE_ADDR))
              || (wa_full[31:SRAM_AW-1] != '0);
`else
  logic unused_wa_hi;
  assign unused_wa_hi = ^wa_full[31:SRAM_AW-1];
  assign fault        = 1'b0;
`endif

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (~cnt_en),
    .en_i   (cnt_en),
    .last_o (cnt_last),
    .hold_o (cnt_hold)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          rd_d    = cpu.mem_read;
          wa_d    = wa_full[SRAM_AW-2:0];
          wdata_d = cpu.wdata;
          if (fault) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_HI;
          if (rd_q) rdata_d[15:0] = sram_dq_in;
        end
      end
      ST_HI: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
          if (rd_q) rdata_d[31:16] = sram_dq_in;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad strobes are decoded from registered state so an async reset idles them at once.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state_q == ST_LO || state_q == ST_HI) begin
      sram_addr = {wa_q, (state_q == ST_HI)};
      if (rd_q) begin
        sram_oe_n = 1'b0;
      end else begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = cnt_hold;
        sram_dq_out = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  assign cpu.ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign cpu.rdata = rdata_q;
  assign cpu.err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: an access-level timing model plus a
// behavioural SRAM, directed spec scenarios and a randomized access stream.
module tb_sram_access_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned W    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in = '0;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  sram_access_ctrl_if cpu ();

  sram_access_ctrl #(
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Behavioural SRAM: unwritten locations read back an address-derived pattern.
  logic [15:0] sram_mem [int unsigned];
  logic [15:0] ref_mem  [int unsigned];

  function automatic logic [15:0] fill(input int unsigned a);
    return 16'(a * 32'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_out;

  always @(negedge clk)
    if (sram_oe_n) sram_dq_in = '0;
    else sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : fill(int'(sram_addr));

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(int'(a));
  endfunction

  function automatic logic [AW-1:0] model_lo(input logic [31:0] a);
    logic [31:0] wa;
    wa = (a - BASE) >> 2;
    return AW'(wa << 1);
  endfunction

  function automatic bit model_fault(input logic [31:0] a);
`ifdef SRAM_ACCESS_CTRL_ADDR_CHECK_EN
    logic [31:0] wa;
    wa = (a - BASE) >> 2;
    return (a[1:0] != 2'b00) || (a < BASE) || (wa >= (32'd1 << (AW - 1)));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  bit            chk_on = 1'b0;
  logic          exp_ready, exp_err, exp_we_n, exp_oe_n, exp_dq_oe, exp_bus;
  logic [AW-1:0] exp_addr;
  logic [15:0]   exp_dq_out;
  logic [31:0]   exp_rdata;

  typedef struct packed {
    logic          ready;
    logic          err;
    logic          we_n;
    logic          oe_n;
    logic          dq_oe;
    logic [AW-1:0] addr;
    logic [15:0]   dq_out;
    logic [31:0]   rdata;
  } obs_t;
  obs_t hist [$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", cpu.ready, exp_ready);
      chk("err", cpu.err, exp_err);
      chk("rdata", cpu.rdata, exp_rdata);
      chk("we_n", sram_we_n, exp_we_n);
      chk("oe_n", sram_oe_n, exp_oe_n);
      chk("dq_oe", sram_dq_oe, exp_dq_oe);
      if (exp_bus) begin
        chk("sram_addr", sram_addr, exp_addr);
        if (exp_dq_oe) chk("dq_out", sram_dq_out, exp_dq_out);
      end
      hist.push_back('{cpu.ready, cpu.err, sram_we_n, sram_oe_n, sram_dq_oe,
                       sram_addr, sram_dq_out, cpu.rdata});
    end
  end

  task automatic exp_idle();
    exp_ready = 1'b1; exp_err = 1'b0; exp_we_n = 1'b1; exp_oe_n = 1'b1;
    exp_dq_oe = 1'b0; exp_bus = 1'b0;
  endtask

  task automatic drop_req();
    cpu.mem_read  = 1'b0;
    cpu.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drop_req();
      exp_idle();
    end
  endtask

  // One MEM-stage access starting in the next cycle (cycle 0 = IDLE cycle with request).
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit garble, input bit mark, input int rst_k);
    logic [AW-1:0] lo_a, hi_a;
    logic [31:0]   new_rd;
    bit            is_rd, flt;
    int            h, c;
    is_rd  = rd;
    flt    = model_fault(a);
    lo_a   = model_lo(a);
    hi_a   = lo_a | AW'(1);
    new_rd = {ref_rd(hi_a), ref_rd(lo_a)};
    @(posedge clk); #1;
    if (mark) hist.delete();
    cpu.mem_read = rd; cpu.mem_write = wr; cpu.address = a; cpu.wdata = d;
    exp_idle();
    exp_ready = 1'b0;
    if (flt) begin
      @(posedge clk); #1;
      drop_req();
      exp_idle();
      exp_err = 1'b1;
      return;
    end
    for (int k = 1; k <= int'(2 * W); k++) begin
      @(posedge clk); #1;
      if (k == rst_k) begin
        drop_req();
        rst = 1'b0;
        exp_idle();
        exp_rdata = '0;
        if (!is_rd) begin
          if (k > 1) ref_mem[int'(lo_a)] = d[15:0];
          if (k > int'(W) + 1) ref_mem[int'(hi_a)] = d[31:16];
        end
        #1;
        chk("rst_ready", cpu.ready, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_rdata", cpu.rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (garble) begin
        cpu.mem_read  = 1'($urandom_range(0, 1));
        cpu.mem_write = 1'($urandom_range(0, 1));
        cpu.address   = $urandom();
        cpu.wdata     = $urandom();
      end
      h = (k - 1) / int'(W);
      c = (k - 1) % int'(W);
      exp_ready = 1'b0; exp_err = 1'b0; exp_bus = 1'b1;
      exp_addr  = (h != 0) ? hi_a : lo_a;
      if (is_rd) begin
        exp_oe_n = 1'b0; exp_we_n = 1'b1; exp_dq_oe = 1'b0;
        if (k == int'(W) + 1) exp_rdata[15:0] = new_rd[15:0];
      end else begin
        exp_oe_n   = 1'b1; exp_dq_oe = 1'b1;
        exp_we_n   = (c == int'(W) - 1);
        exp_dq_out = (h != 0) ? d[31:16] : d[15:0];
      end
    end
    @(posedge clk); #1;
    drop_req();
    exp_idle();
    if (is_rd) exp_rdata = new_rd;
    else begin
      ref_mem[int'(lo_a)] = d[15:0];
      ref_mem[int'(hi_a)] = d[31:16];
    end
  endtask

  function automatic int busy_len();
    int n = 0;
    foreach (hist[i]) if (!hist[i].ready) n++;
    return n;
  endfunction

  initial begin
    logic [5:0]  we_pat;
    logic [31:0] a;
    int          r;
    we_pat = 6'b100100;
    drop_req();
    cpu.address = '0;
    cpu.wdata   = '0;
    exp_idle();
    exp_rdata = '0;
    #1;
    chk("reset_ready", cpu.ready, 1);
    chk("reset_rdata", cpu.rdata, 0);
    chk("reset_err", cpu.err, 0);
    chk("reset_we_n", sram_we_n, 1);
    chk("reset_oe_n", sram_oe_n, 1);
    chk("reset_dq_oe", sram_dq_oe, 0);
    chk("reset_addr", sram_addr, 0);
    chk("reset_dq_out", sram_dq_out, 0);
    chk("model_lo_1028", model_lo(32'd1028), 2);
    chk("model_lo_1024", model_lo(32'd1024), 0);
    @(posedge clk); @(posedge clk); #1;
    rst    = 1'b1;
    chk_on = 1'b1;

    // Store then load at 1024.
    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
    idle(1);
    chk("st_addr_lo", hist[1].addr, 0);
    chk("st_addr_hi", hist[4].addr, 1);
    chk("st_dq_lo", hist[1].dq_out, 16'hBEEF);
    chk("st_dq_hi", hist[4].dq_out, 16'hDEAD);
    chk("st_busy", busy_len(), 7);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, 0);
    idle(1);
    chk("ld_rdata", hist[7].rdata, 32'hDEAD_BEEF);

    // Strobe timing, store at 1028.
    access(1'b0, 1'b1, 32'd1028, 32'hCAFE_F00D, 1'b0, 1'b1, 0);
    idle(1);
    chk("strobe_addr_lo", hist[1].addr, 2);
    chk("strobe_addr_hi", hist[4].addr, 3);
    for (int k = 1; k <= 6; k++) begin
      chk("strobe_we_n", hist[k].we_n, we_pat[k-1]);
      chk("strobe_dq_oe", hist[k].dq_oe, 1);
    end
    chk("strobe_dq_oe_c0", hist[0].dq_oe, 0);
    chk("strobe_dq_oe_c7", hist[7].dq_oe, 0);
    foreach (hist[i]) chk("strobe_oe_n", hist[i].oe_n, 1);

    // Read wins over write when both are requested.
    access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 1'b0, 1'b0, 0);
    access(1'b1, 1'b1, 32'd1032, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    idle(1);
    chk("both_oe_n", hist[3].oe_n, 0);
    chk("both_we_n", hist[2].we_n, 1);
    chk("both_rdata", hist[7].rdata, 32'h1234_5678);
    chk("both_sram_lo", sram_mem[4], 16'h5678);

    // Reset during HI of a store, then a normal read.
    access(1'b0, 1'b1, 32'd1024, 32'h1122_3344, 1'b0, 1'b0, int'(W) + 1);
    idle(1);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, 0);
    idle(1);
    chk("post_rst_busy", busy_len(), 7);
    chk("post_rst_rdata", hist[7].rdata, 32'hDEAD_3344);

    // Back-to-back loads.
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, 0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0, 0);
    idle(1);
    chk("b2b_ready7", hist[7].ready, 1);
    chk("b2b_ready8", hist[8].ready, 0);
    chk("b2b_ready14", hist[14].ready, 0);
    chk("b2b_ready15", hist[15].ready, 1);
    chk("b2b_rdata1", hist[7].rdata, 32'hDEAD_3344);
    chk("b2b_rdata2", hist[15].rdata, 32'hCAFE_F00D);

`ifdef SRAM_ACCESS_CTRL_ADDR_CHECK_EN
    access(1'b1, 1'b0, 32'd1026, 32'h0, 1'b0, 1'b1, 0);
    idle(1);
    chk("misalign_busy", busy_len(), 1);
    chk("misalign_err", hist[1].err, 1);
    chk("misalign_err_off", hist[2].err, 0);
    chk("misalign_oe_n", hist[0].oe_n & hist[1].oe_n, 1);
    chk("misalign_rdata", hist[1].rdata, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'd512, 32'h0, 1'b0, 1'b1, 0);
    idle(1);
    chk("low_busy", busy_len(), 1);
    chk("low_err", hist[1].err, 1);
    chk("low_rdata", hist[1].rdata, 32'hCAFE_F00D);
`endif

    // Randomized access stream with mid-access input noise and random gaps.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) a = BASE + 4 * $urandom_range(0, 15);
      else if (r < 8) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else a = $urandom();
      r = int'($urandom_range(0, 2));
      access((r != 0), (r != 1), a, $urandom(), 1'($urandom_range(0, 1)), 1'b0, 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
